// File: rtl/mem_dump_reader.sv
// rtl/mem_dump_reader.sv - BRAM readback sweep engine streaming address-tagged words
// Define MEM_DUMP_CHECKSUM_EN to add the running 32-bit checksum output.
module mem_dump_reader #(
  parameter int WID_MEM   = 32,
  parameter int DEPTH_MEM = 2048,
  parameter int ADDR_W    = $clog2(DEPTH_MEM)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  first_addr,
  input  logic [ADDR_W-1:0]  last_addr,
  output logic [ADDR_W-1:0]  raddr,
  input  logic [WID_MEM-1:0] rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WID_MEM-1:0] out_data,
  output logic [ADDR_W-1:0]  out_addr,
  output logic               busy,
  output logic               done
`ifdef MEM_DUMP_CHECKSUM_EN
  ,
  output logic [31:0]        checksum
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH_MEM - 1);
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH_MEM);
  localparam logic [ADDR_W:0]   ONE_X    = (ADDR_W+1)'(1);

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  raddr_q, raddr_d;
  logic [ADDR_W:0]    n_q, n_d;
  logic [ADDR_W:0]    issued_q, issued_d;
  logic               inflight_q, inflight_d;
  logic [ADDR_W-1:0]  inflight_addr_q, inflight_addr_d;
  logic [1:0]         buf_cnt_q, buf_cnt_d;
  logic               wr_ptr_q, rd_ptr_q;
  logic [WID_MEM-1:0] fifo_data_q [2];
  logic [ADDR_W-1:0]  fifo_addr_q [2];

  logic               start_acc, pop, pop_buf, push, issue, bypass;
  logic [1:0]         occ;
  logic [ADDR_W:0]    span;

  assign start_acc = (state_q == S_IDLE) && start;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DRAIN) && (buf_cnt_q == 2'd0) && !inflight_q;

  // An empty buffer lets the arriving RAM word go straight to the output;
  // if it is not taken this cycle it lands in the FIFO, keeping the payload stable.
  assign bypass    = (buf_cnt_q == 2'd0) && inflight_q;
  assign out_valid = (buf_cnt_q != 2'd0) || inflight_q;
  assign out_data  = bypass ? rdata : fifo_data_q[rd_ptr_q];
  assign out_addr  = bypass ? inflight_addr_q : fifo_addr_q[rd_ptr_q];
  assign raddr     = raddr_q;

  assign pop     = out_valid && out_ready;
  assign pop_buf = pop && (buf_cnt_q != 2'd0);
  assign push    = inflight_q && !(bypass && pop);

  assign occ   = buf_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
  assign issue = (state_q == S_RUN) && (issued_q < n_q) && (occ < 2'd2);

  assign span = (last_addr >= first_addr) ? ({1'b0, last_addr} - {1'b0, first_addr})
                                          : ({1'b0, last_addr} + DEPTH_X - {1'b0, first_addr});

  always_comb begin
    state_d         = state_q;
    raddr_d         = raddr_q;
    n_d             = n_q;
    issued_d        = issued_q;
    inflight_d      = issue;
    inflight_addr_d = issue ? raddr_q : inflight_addr_q;
    buf_cnt_d       = buf_cnt_q + {1'b0, push} - {1'b0, pop_buf};
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          raddr_d  = first_addr;
          n_d      = span + ONE_X;
          issued_d = '0;
        end
      end
      S_RUN: begin
        if (issue) begin
          raddr_d  = (raddr_q == ADDR_MAX) ? '0 : raddr_q + ADDR_W'(1);
          issued_d = issued_q + ONE_X;
          if (issued_q == n_q - ONE_X) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((buf_cnt_q == 2'd0) && !inflight_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      raddr_q         <= '0;
      n_q             <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      buf_cnt_q       <= 2'd0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      fifo_data_q[0]  <= '0;
      fifo_data_q[1]  <= '0;
      fifo_addr_q[0]  <= '0;
      fifo_addr_q[1]  <= '0;
    end else begin
      state_q         <= state_d;
      raddr_q         <= raddr_d;
      n_q             <= n_d;
      issued_q        <= issued_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
      buf_cnt_q       <= buf_cnt_d;
      wr_ptr_q        <= wr_ptr_q ^ push;
      rd_ptr_q        <= rd_ptr_q ^ pop_buf;
      if (push) begin
        fifo_data_q[wr_ptr_q] <= rdata;
        fifo_addr_q[wr_ptr_q] <= inflight_addr_q;
      end
    end
  end

`ifdef MEM_DUMP_CHECKSUM_EN
  localparam int CW = (WID_MEM < 32) ? WID_MEM : 32;

  logic [31:0] checksum_q;
  logic [31:0] sum_term;

  assign sum_term = 32'(out_data[CW-1:0]);
  assign checksum = checksum_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_q <= '0;
    end else if (start_acc) begin
      checksum_q <= '0;
    end else if (pop) begin
      checksum_q <= checksum_q + sum_term;
    end
  end
`endif

endmodule

// File: tb/tb_mem_dump_reader.sv
// tb/tb_mem_dump_reader.sv - scoreboard bench for mem_dump_reader on a 16x32 RAM model
// Run with MEM_DUMP_CHECKSUM_EN defined to also check the checksum port.
module tb_mem_dump_reader;
  localparam int W  = 32;
  localparam int D  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] first_addr = '0;
  logic [AW-1:0] last_addr = '0;
  logic [AW-1:0] raddr, out_addr;
  logic [W-1:0]  rdata = '0;
  logic [W-1:0]  out_data;
  logic          out_valid, busy, done;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  int checks = 0;
  int passes = 0;
  int hs_count = 0;
  logic [W-1:0]  exp_data_q [$];
  logic [AW-1:0] exp_addr_q [$];
  bit            stall_prev = 1'b0;
  logic [W-1:0]  stall_data = '0;
  logic [AW-1:0] stall_addr = '0;

  always #5 clk = ~clk;

  // RAM model: registered read, mem[i] = A000_0000 + i
  always @(posedge clk) rdata <= 32'hA000_0000 + 32'(raddr);

  mem_dump_reader #(.WID_MEM(W), .DEPTH_MEM(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .raddr      (raddr),
    .rdata      (rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .busy       (busy),
    .done       (done)
`ifdef MEM_DUMP_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", 64'(out_data), 64'(stall_data));
        check("stall_addr", 64'(out_addr), 64'(stall_addr));
      end
      if (out_valid && out_ready) begin
        if (exp_data_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_word: got addr %0h data %0h expected none", out_addr, out_data);
        end else begin
          check("word_data", 64'(out_data), 64'(exp_data_q.pop_front()));
          check("word_addr", 64'(out_addr), 64'(exp_addr_q.pop_front()));
        end
        hs_count++;
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      stall_addr = out_addr;
    end
  end

  task automatic push_expected(input int f, input int n);
    int a;
    a = f;
    for (int i = 0; i < n; i++) begin
      exp_data_q.push_back(32'hA000_0000 + 32'(a));
      exp_addr_q.push_back(AW'(a));
      a = (a == D - 1) ? 0 : a + 1;
    end
  endtask

  // mode 0: ready high; 1: random ready with two 10-cycle stalls; 2: ready high plus ignored starts
  task automatic sweep(input string tag, input int f, input int l, input int n, input int mode,
                       input logic [31:0] cs);
    int k, first_v, done_k, hs0;
    bit quiet;
    string t;
    t = $sformatf("%s[cs=%0h]", tag, cs);
    push_expected(f, n);
    hs0 = hs_count;
    first_v = -1;
    done_k = -1;
    @(posedge clk); #1;
    start = 1'b1; first_addr = AW'(f); last_addr = AW'(l); out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (done_k < 0 && k < 400) begin
      if (mode == 1)
        out_ready = ((k >= 3 && k < 13) || (k >= 20 && k < 30)) ? 1'b0 : 1'($urandom_range(0, 1));
      else
        out_ready = 1'b1;
      if (mode == 2 && k == 5) begin start = 1'b1; first_addr = 4'd3; last_addr = 4'd3; end
      if (mode == 2 && k == 6) start = 1'b0;
      if (mode == 2 && k == n + 1) start = 1'b1;
      @(negedge clk);
      if (out_valid && first_v < 0) first_v = k;
      if (done) done_k = k;
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    check({t, "_done_seen"}, 64'(done_k >= 0), 64'd1);
    if (mode != 1) begin
      check({t, "_first_valid_cycle"}, 64'(first_v), 64'd1);
      check({t, "_done_cycle"}, 64'(done_k), 64'(n + 1));
    end
    @(negedge clk);
    check({t, "_busy_after_done"}, 64'(busy), 64'd0);
    check({t, "_done_pulse_width"}, 64'(done), 64'd0);
    check({t, "_word_count"}, 64'(hs_count - hs0), 64'(n));
    check({t, "_queue_empty"}, 64'(exp_data_q.size()), 64'd0);
`ifdef MEM_DUMP_CHECKSUM_EN
    check({t, "_checksum"}, 64'(checksum), 64'(cs));
`endif
    if (mode == 2) begin
      quiet = 1'b1;
      repeat (20) begin
        @(negedge clk);
        if (out_valid || busy) quiet = 1'b0;
      end
      check({t, "_no_second_sweep"}, 64'(quiet), 64'd1);
      check({t, "_word_count_after"}, 64'(hs_count - hs0), 64'(n));
    end
    exp_data_q.delete();
    exp_addr_q.delete();
  endtask

  task automatic reset_mid_sweep();
    int k, hs0;
    bit no_done;
    push_expected(0, 16);
    hs0 = hs_count;
    @(posedge clk); #1;
    start = 1'b1; first_addr = 4'd0; last_addr = 4'd15; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (hs_count - hs0 < 6 && k < 100) begin
      @(posedge clk);
      k++;
    end
    check("rst_six_words_reached", 64'(k < 100), 64'd1);
    #1;
    reset = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_data_q.delete();
    exp_addr_q.delete();
    check("rst_words_before_reset", 64'(hs_count - hs0), 64'd6);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    no_done = !done;
    repeat (5) begin
      @(negedge clk);
      if (done || out_valid) no_done = 1'b0;
    end
    check("rst_no_done_pulse", 64'(no_done), 64'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_raddr", 64'(raddr), 64'd0);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data", 64'(out_data), 64'd0);
    check("reset_out_addr", 64'(out_addr), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
`ifdef MEM_DUMP_CHECKSUM_EN
    check("reset_checksum", 64'(checksum), 64'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;

    sweep("full", 0, 15, 16, 0, 32'h0000_0078);
    sweep("wrap", 14, 1, 4, 0, 32'h8000_001E);
    sweep("single", 5, 5, 1, 0, 32'hA000_0005);
    sweep("stall", 0, 15, 16, 1, 32'h0000_0078);
    reset_mid_sweep();
    sweep("after_reset", 0, 15, 16, 0, 32'h0000_0078);
    sweep("busy_start", 0, 15, 16, 2, 32'h0000_0078);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
